// File: rtl/input_stream_bank.sv
// Bank of independent input streams feeding the CPU IN ports. Each channel has
// its own memory, length, read pointer, sticky underrun flag and optional wrap.
module input_stream_bank #(
  parameter int WIDTH    = 12,
  parameter int ADDR_W   = 13,
  parameter int CHANNELS = 2,
  parameter int CH_W     = 1,
  parameter int WRAP     = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [CHANNELS-1:0]          adv,
  input  logic                         rewind,
  output logic [CHANNELS*WIDTH-1:0]    data,
  output logic [CHANNELS-1:0]          valid,
  output logic [CHANNELS-1:0]          underrun,
  input  logic                         load_we,
  input  logic [CH_W-1:0]              load_chan,
  input  logic [ADDR_W-1:0]            load_addr,
  input  logic [WIDTH-1:0]             load_data,
  input  logic                         len_we,
  input  logic [ADDR_W:0]              len_in
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] LEN_MAX = (ADDR_W + 1)'(DEPTH);

  logic [WIDTH-1:0]  mem [CHANNELS][DEPTH];
  logic [ADDR_W:0]   ptr_q  [CHANNELS];
  logic [ADDR_W:0]   ptr_d  [CHANNELS];
  logic [ADDR_W:0]   len_q  [CHANNELS];
  logic [ADDR_W:0]   len_d  [CHANNELS];
  logic [WIDTH-1:0]  data_q [CHANNELS];
  logic [WIDTH-1:0]  data_d [CHANNELS];
  logic [CHANNELS-1:0] und_q;
  logic [CHANNELS-1:0] und_d;
  logic [CHANNELS-1:0] valid_s;

  // Next-state for pointers, lengths, underrun flags and the lookahead read.
  always_comb begin
    und_d = und_q;
    for (int c = 0; c < CHANNELS; c++) begin
      valid_s[c] = (ptr_q[c] < len_q[c]);
      ptr_d[c]   = ptr_q[c];
      len_d[c]   = len_q[c];
      if (len_we && (load_chan == CH_W'(c))) begin
        len_d[c] = (len_in > LEN_MAX) ? LEN_MAX : len_in;
      end else begin
        len_d[c] = len_q[c];
      end
      // Advance/exhaust decision is made against the old length.
      if (rewind) begin
        ptr_d[c] = '0;
        und_d[c] = 1'b0;
      end else if (adv[c]) begin
        if (!valid_s[c]) begin
          und_d[c] = 1'b1;
        end else if ((WRAP != 0) && ((ptr_q[c] + (ADDR_W + 1)'(1)) == len_q[c])) begin
          ptr_d[c] = '0;
        end else begin
          ptr_d[c] = ptr_q[c] + (ADDR_W + 1)'(1);
        end
      end else begin
        ptr_d[c] = ptr_q[c];
      end
      if (ptr_d[c] < len_d[c]) begin
        data_d[c] = mem[c][ptr_d[c][ADDR_W-1:0]];
      end else begin
        data_d[c] = '0;
      end
    end
  end

  // Pointer, underrun and data registers; cleared by rst.
  always_ff @(posedge clk) begin
    if (rst) begin
      und_q <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        ptr_q[c]  <= '0;
        data_q[c] <= '0;
      end
    end else begin
      und_q <= und_d;
      for (int c = 0; c < CHANNELS; c++) begin
        ptr_q[c]  <= ptr_d[c];
        data_q[c] <= data_d[c];
      end
    end
  end

  // Stream lengths survive rst so a loaded test can be rerun.
  always_ff @(posedge clk) begin
    for (int c = 0; c < CHANNELS; c++) begin
      len_q[c] <= len_d[c];
    end
  end

  // Memory load port; the read above sees the pre-write contents.
  always_ff @(posedge clk) begin
    for (int c = 0; c < CHANNELS; c++) begin
      if (load_we && (load_chan == CH_W'(c))) begin
        mem[c][load_addr] <= load_data;
      end
    end
  end

  // Pack per-channel registers onto the output buses.
  always_comb begin
    data = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      data[c*WIDTH +: WIDTH] = data_q[c];
    end
  end

  assign valid    = valid_s;
  assign underrun = und_q;

endmodule

// File: tb/tb_input_stream_bank.sv
// Directed bench for input_stream_bank: one non-wrapping and one wrapping
// instance driven with identical stimulus.
module tb_input_stream_bank;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  adv;
  logic        rewind;
  logic        load_we;
  logic [0:0]  load_chan;
  logic [12:0] load_addr;
  logic [11:0] load_data;
  logic        len_we;
  logic [13:0] len_in;

  logic [23:0] a_data, b_data;
  logic [1:0]  a_valid, b_valid, a_und, b_und;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  input_stream_bank #(.WRAP(0)) dut_a (
    .clk(clk), .rst(rst), .adv(adv), .rewind(rewind),
    .data(a_data), .valid(a_valid), .underrun(a_und),
    .load_we(load_we), .load_chan(load_chan), .load_addr(load_addr),
    .load_data(load_data), .len_we(len_we), .len_in(len_in)
  );

  input_stream_bank #(.WRAP(1)) dut_b (
    .clk(clk), .rst(rst), .adv(adv), .rewind(rewind),
    .data(b_data), .valid(b_valid), .underrun(b_und),
    .load_we(load_we), .load_chan(load_chan), .load_addr(load_addr),
    .load_data(load_data), .len_we(len_we), .len_in(len_in)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int ch, input int addr, input int val);
    load_we   = 1'b1;
    load_chan = 1'(ch);
    load_addr = 13'(addr);
    load_data = 12'(val);
    tick();
    load_we = 1'b0;
  endtask

  task automatic set_len(input int ch, input int len);
    len_we    = 1'b1;
    load_chan = 1'(ch);
    len_in    = 14'(len);
    tick();
    len_we = 1'b0;
  endtask

  task automatic do_rewind();
    rewind = 1'b1;
    tick();
    rewind = 1'b0;
  endtask

  logic [11:0] exp_a1 [4] = '{12'h222, 12'h333, 12'h000, 12'h000};
  logic        exp_v1 [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
  logic        exp_u1 [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
  logic [11:0] exp_b1 [7] = '{12'h222, 12'h333, 12'h111, 12'h222, 12'h333, 12'h111, 12'h222};

  initial begin
    rst = 1'b1; adv = 2'b00; rewind = 1'b0;
    load_we = 1'b0; load_chan = 1'b0; load_addr = '0; load_data = '0;
    len_we = 1'b0; len_in = '0;
    tick(); tick();

    // Loads and length writes land while rst is held.
    load(0, 0, 12'h111); load(0, 1, 12'h222); load(0, 2, 12'h333);
    set_len(0, 3); set_len(1, 0);
    tick();
    check("reset_data", 32'(a_data), 32'h0);
    check("reset_valid", 32'(a_valid), 32'h1);
    check("reset_underrun", 32'(a_und), 32'h0);

    rst = 1'b0;
    tick();
    check("first_word_a", 32'(a_data[11:0]), 32'h111);
    check("first_word_b", 32'(b_data[11:0]), 32'h111);

    // Stream through and past the end.
    adv = 2'b01;
    for (int i = 0; i < 7; i++) begin
      tick();
      if (i < 4) begin
        check($sformatf("seq_a_data%0d", i), 32'(a_data[11:0]), 32'(exp_a1[i]));
        check($sformatf("seq_a_valid%0d", i), 32'(a_valid[0]), 32'(exp_v1[i]));
        check($sformatf("seq_a_und%0d", i), 32'(a_und[0]), 32'(exp_u1[i]));
      end
      check($sformatf("wrap_b_data%0d", i), 32'(b_data[11:0]), 32'(exp_b1[i]));
    end
    adv = 2'b00;
    check("wrap_b_und", 32'(b_und), 32'h0);

    // Independent channels.
    for (int i = 0; i < 5; i++) load(1, i, 12'hA01 + i);
    set_len(0, 2); set_len(1, 5);
    do_rewind();
    check("rew_ch0", 32'(a_data[11:0]), 32'h111);
    check("rew_ch1", 32'(a_data[23:12]), 32'hA01);
    check("rew_und", 32'(a_und), 32'h0);
    adv = 2'b10;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("ind_ch1_%0d", i), 32'(a_data[23:12]), 32'(12'hA02 + i));
      check($sformatf("ind_ch0_%0d", i), 32'(a_data[11:0]), 32'h111);
      check($sformatf("ind_b_ch1_%0d", i), 32'(b_data[23:12]), 32'(12'hA02 + i));
    end
    check("ind_valid", 32'(a_valid), 32'h3);

    // Exhaust ch0, then rewind with a simultaneous advance.
    adv = 2'b01;
    tick(); check("exh_data0", 32'(a_data[11:0]), 32'h222);
    tick(); check("exh_data1", 32'(a_data[11:0]), 32'h0);
            check("exh_valid1", 32'(a_valid[0]), 32'h0);
            check("exh_und1", 32'(a_und[0]), 32'h0);
    tick(); check("exh_und2", 32'(a_und[0]), 32'h1);
    rewind = 1'b1;
    tick();
    rewind = 1'b0; adv = 2'b00;
    check("rewadv_data", 32'(a_data[11:0]), 32'h111);
    check("rewadv_und", 32'(a_und), 32'h0);
    check("rewadv_valid", 32'(a_valid[0]), 32'h1);

    // Read-before-write on the address being advanced to.
    adv = 2'b01; load_we = 1'b1; load_chan = 1'b0; load_addr = 13'd1; load_data = 12'hFFF;
    tick();
    adv = 2'b00; load_we = 1'b0;
    check("rbw_old", 32'(a_data[11:0]), 32'h222);
    do_rewind();
    check("rbw_rew", 32'(a_data[11:0]), 32'h111);
    adv = 2'b01; tick(); adv = 2'b00;
    check("rbw_new", 32'(a_data[11:0]), 32'hFFF);

    // Full depth via clamped length.
    set_len(0, 14'h3FFF);
    load(0, 8191, 12'hABC);
    do_rewind();
    adv = 2'b01;
    repeat (8191) tick();
    check("depth_data", 32'(a_data[11:0]), 32'hABC);
    check("depth_valid", 32'(a_valid[0]), 32'h1);
    tick();
    adv = 2'b00;
    check("depth_end_data", 32'(a_data[11:0]), 32'h0);
    check("depth_end_valid", 32'(a_valid[0]), 32'h0);
    check("depth_wrap_b_data", 32'(b_data[11:0]), 32'h111);
    check("depth_wrap_b_valid", 32'(b_valid[0]), 32'h1);

    // rst mid-stream with a simultaneous load.
    do_rewind();
    adv = 2'b01; tick(); tick(); adv = 2'b00;
    rst = 1'b1; load_we = 1'b1; load_chan = 1'b0; load_addr = 13'd0; load_data = 12'h777;
    tick();
    rst = 1'b0; load_we = 1'b0;
    check("mid_rst_data", 32'(a_data), 32'h0);
    check("mid_rst_valid", 32'(a_valid), 32'h3);
    check("mid_rst_und", 32'(a_und), 32'h0);
    tick();
    check("mid_rst_word0", 32'(a_data[11:0]), 32'h777);
    check("mid_rst_ch1", 32'(a_data[23:12]), 32'hA01);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
